// File: rtl/spread_charge_accumulator_if.sv
// ---------------------------------------------------------------------------
// spread_charge_accumulator_if : tier-pair beat input and portfolio summary output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spread_charge_accumulator_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [15:0]      in_spread;
  logic [15:0]      in_outright;
  logic [6:0]       in_resid_long;
  logic [6:0]       in_resid_short;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] total_spread;
  logic [ACC_W-1:0] total_outright;
  logic [6:0]       resid_long;
  logic [6:0]       resid_short;
  logic [3:0]       pair_count;
  logic             overflow;
  logic             error;

  modport slave (
    input  in_valid, in_last, in_spread, in_outright, in_resid_long, in_resid_short, out_ready,
    output in_ready, out_valid, total_spread, total_outright, resid_long, resid_short,
           pair_count, overflow, error
  );

  modport master (
    output in_valid, in_last, in_spread, in_outright, in_resid_long, in_resid_short, out_ready,
    input  in_ready, out_valid, total_spread, total_outright, resid_long, resid_short,
           pair_count, overflow, error
  );
endinterface

`default_nettype wire

// File: rtl/spread_charge_accumulator.sv
// ---------------------------------------------------------------------------
// spread_charge_accumulator : saturating per-portfolio sum of tier-pair spread results
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spread_charge_accumulator #(
  parameter int MAX_PAIRS = 6,
  parameter int ACC_W     = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  spread_charge_accumulator_if.slave   bus
);

  // Internal counter may be wider than the 4-bit port so large MAX_PAIRS still closes
  localparam int CNT_W = ($clog2(MAX_PAIRS + 1) > 4) ? $clog2(MAX_PAIRS + 1) : 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [ACC_W-1:0]   acc_spread;
  logic [ACC_W-1:0]   acc_outright;
  logic [6:0]         res_long;
  logic [6:0]         res_short;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               err;

  logic               accept;
  logic               release_summary;
  logic [CNT_W-1:0]   count_next;
  logic               at_max;
  logic [ACC_W:0]     spread_sum;
  logic [ACC_W:0]     outright_sum;
  logic               spread_sat;
  logic               outright_sat;
  logic [ACC_W-1:0]   spread_next;
  logic [ACC_W-1:0]   outright_next;

  assign accept          = bus.in_valid && (state != HOLD);
  assign release_summary = (state == HOLD) && bus.out_ready;
  assign count_next      = count + CNT_W'(1);
  assign at_max          = (count_next == CNT_W'(MAX_PAIRS));

  always_comb begin
    spread_sum    = {1'b0, acc_spread} + {{(ACC_W-15){1'b0}}, bus.in_spread};
    outright_sum  = {acc_outright[ACC_W-1], acc_outright}
                  + {{(ACC_W-15){bus.in_outright[15]}}, bus.in_outright};
    spread_sat    = spread_sum[ACC_W];
    // Sign disagreement between the guard bit and the top bit marks a signed overflow
    outright_sat  = outright_sum[ACC_W] ^ outright_sum[ACC_W-1];
    spread_next   = spread_sat ? {ACC_W{1'b1}} : spread_sum[ACC_W-1:0];
    outright_next = outright_sum[ACC_W-1:0];
    if (outright_sat) begin
      outright_next = outright_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          next_state = (bus.in_last || at_max) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || release_summary) begin
      acc_spread   <= '0;
      acc_outright <= '0;
      res_long     <= '0;
      res_short    <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      err          <= 1'b0;
    end else if (accept) begin
      acc_spread   <= spread_next;
      acc_outright <= outright_next;
      res_long     <= bus.in_resid_long;
      res_short    <= bus.in_resid_short;
      count        <= count_next;
      ovf          <= ovf | spread_sat | outright_sat;
      err          <= err | (at_max && !bus.in_last);
    end
  end

  assign bus.in_ready       = (state != HOLD);
  assign bus.out_valid      = (state == HOLD);
  assign bus.total_spread   = acc_spread;
  assign bus.total_outright = acc_outright;
  assign bus.resid_long     = res_long;
  assign bus.resid_short    = res_short;
  assign bus.pair_count     = count[3:0];
  assign bus.overflow       = ovf;
  assign bus.error          = err;

endmodule

`default_nettype wire

// File: tb/tb_spread_charge_accumulator.sv
// ---------------------------------------------------------------------------
// tb_spread_charge_accumulator : directed checks of portfolio summaries and saturation
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spread_charge_accumulator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  spread_charge_accumulator_if #(.ACC_W(20)) bus_a ();
  spread_charge_accumulator_if #(.ACC_W(20)) bus_b ();

  spread_charge_accumulator #(.MAX_PAIRS(6), .ACC_W(20)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  spread_charge_accumulator #(.MAX_PAIRS(17), .ACC_W(20)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic beat(input logic [15:0] sp, input logic [15:0] ot,
                      input logic [6:0] rl, input logic [6:0] rs, input logic last);
    bus_a.in_valid       = 1'b1;
    bus_a.in_spread      = sp;
    bus_a.in_outright    = ot;
    bus_a.in_resid_long  = rl;
    bus_a.in_resid_short = rs;
    bus_a.in_last        = last;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic handshake_a();
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 0; bus_a.in_last = 0; bus_a.in_spread = 0; bus_a.in_outright = 0;
    bus_a.in_resid_long = 0; bus_a.in_resid_short = 0; bus_a.out_ready = 0;
    bus_b.in_valid = 0; bus_b.in_last = 0; bus_b.in_spread = 0; bus_b.in_outright = 0;
    bus_b.in_resid_long = 0; bus_b.in_resid_short = 0; bus_b.out_ready = 0;

    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready",  bus_a.in_ready, 1);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_spread",    bus_a.total_spread, 0);
    chk("rst_outright",  bus_a.total_outright, 0);
    chk("rst_count",     bus_a.pair_count, 0);
    chk("rst_flags",     {bus_a.overflow, bus_a.error}, 0);

    // Three-beat portfolio
    beat(16'd10, 16'd2, 7'd9, 7'd9, 1'b0);
    chk("p1_mid_valid", bus_a.out_valid, 0);
    beat(16'd20, 16'hFFFB, 7'd3, 7'd3, 1'b0);
    beat(16'd30, 16'd0, 7'd0, 7'd4, 1'b1);
    chk("p1_valid",    bus_a.out_valid, 1);
    chk("p1_in_ready", bus_a.in_ready, 0);
    chk("p1_spread",   bus_a.total_spread, 60);
    chk("p1_outright", bus_a.total_outright, 20'hFFFFD);
    chk("p1_resid",    {bus_a.resid_long, bus_a.resid_short}, {7'd0, 7'd4});
    chk("p1_count",    bus_a.pair_count, 3);
    chk("p1_flags",    {bus_a.overflow, bus_a.error}, 0);
    handshake_a();
    chk("p1_release_valid", bus_a.out_valid, 0);
    chk("p1_release_ready", bus_a.in_ready, 1);

    // Single zero beat still counts
    beat(16'd0, 16'd0, 7'd7, 7'd0, 1'b1);
    chk("p2_valid",  bus_a.out_valid, 1);
    chk("p2_totals", {bus_a.total_spread, bus_a.total_outright}, 0);
    chk("p2_rlong",  bus_a.resid_long, 7);
    chk("p2_count",  bus_a.pair_count, 1);
    handshake_a();

    // Six beats without in_last: auto close with error
    for (int i = 0; i < 6; i++) begin
      beat(16'd1, 16'd0, 7'd1, 7'd1, 1'b0);
      if (i == 4) chk("p3_open_at5", {bus_a.in_ready, bus_a.out_valid}, 2'b10);
    end
    chk("p3_ready", bus_a.in_ready, 0);
    chk("p3_valid", bus_a.out_valid, 1);
    chk("p3_spread", bus_a.total_spread, 6);
    chk("p3_count", bus_a.pair_count, 6);
    chk("p3_error", bus_a.error, 1);

    // Backpressure in HOLD with a waiting upstream beat
    bus_a.in_valid = 1'b1; bus_a.in_spread = 16'd99; bus_a.in_outright = 16'd1;
    bus_a.in_resid_long = 7'd2; bus_a.in_resid_short = 7'd5; bus_a.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_stable", {bus_a.out_valid, bus_a.in_ready, bus_a.total_spread[15:0]},
          {1'b1, 1'b0, 16'd6});
    end
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    chk("hold_release", {bus_a.out_valid, bus_a.in_ready, bus_a.error}, 3'b010);
    chk("hold_cleared", bus_a.total_spread, 0);
    tick();
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    chk("p4_valid",  bus_a.out_valid, 1);
    chk("p4_spread", bus_a.total_spread, 99);
    chk("p4_count",  bus_a.pair_count, 1);
    chk("p4_error",  bus_a.error, 0);
    handshake_a();

    // in_last at MAX_PAIRS-1 -> close once without error
    for (int i = 0; i < 6; i++) beat(16'd2, 16'd0, 7'd0, 7'd0, i == 5);
    chk("p5_close", {bus_a.out_valid, bus_a.error}, 2'b10);
    chk("p5_count", bus_a.pair_count, 6);
    handshake_a();

    // Reset mid-portfolio discards partial sums
    for (int i = 0; i < 2; i++) beat(16'd50, 16'd3, 7'd1, 7'd1, 1'b0);
    chk("p6_partial", bus_a.total_spread, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("p6_rst_spread", bus_a.total_spread, 0);
    chk("p6_rst_ctrl",  {bus_a.out_valid, bus_a.in_ready, bus_a.pair_count}, {1'b0, 1'b1, 4'd0});
    beat(16'd5, 16'd0, 7'd0, 7'd0, 1'b1);
    chk("p7_spread", bus_a.total_spread, 5);
    chk("p7_count",  bus_a.pair_count, 1);

    // Saturation on the 17-pair instance
    for (int i = 0; i < 17; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_spread = 16'hFFFF; bus_b.in_outright = 16'h8000;
      bus_b.in_last = (i == 16);
      tick();
      if (i == 15) begin
        chk("sat_pre_spread", bus_b.total_spread, 1048560);
        chk("sat_pre_outright", bus_b.total_outright, 20'h80000);
        chk("sat_pre_ovf", bus_b.overflow, 0);
      end
    end
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    chk("sat_spread",   bus_b.total_spread, 1048575);
    chk("sat_outright", bus_b.total_outright, 20'h80000);
    chk("sat_flags",    {bus_b.out_valid, bus_b.overflow, bus_b.error}, 3'b110);
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    chk("sat_release_ovf", bus_b.overflow, 0);

    for (int i = 0; i < 17; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_spread = 16'd0; bus_b.in_outright = 16'h7FFF;
      bus_b.in_last = (i == 16);
      tick();
    end
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    chk("sat_pos_outright", bus_b.total_outright, 20'h7FFFF);
    chk("sat_pos_flags",    {bus_b.overflow, bus_b.total_spread}, {1'b1, 20'd0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
